// File: rtl/axi_slave_scratchpad.sv
// rtl/axi_slave_scratchpad.sv - AXI slave scratchpad RAM with independent write and read burst FSMs
// Optional: define AXI_SLV_RANGE_CHECK_EN to flag beats addressed at or above MEM_WORDS*8 with SLVERR.
module axi_slave_scratchpad #(
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_TID_WIDTH    = 8,
  parameter int AXI_STROBE_WIDTH = 8,
  parameter int MEM_WORDS        = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [AXI_TID_WIDTH-1:0]    s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_STROBE_WIDTH-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [AXI_TID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_TID_WIDTH-1:0]    s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_TID_WIDTH-1:0]    s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(8);

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [1:0]                w_state_q, w_state_d;
  logic [AXI_TID_WIDTH-1:0]  wid_q, wid_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]                wlen_q, wlen_d;
  logic [1:0]                wburst_q, wburst_d;
  logic [7:0]                wcnt_q, wcnt_d;
  logic [1:0]                wresp_q, wresp_d;

  logic [0:0]                r_state_q, r_state_d;
  logic [AXI_TID_WIDTH-1:0]  rid_q, rid_d;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]                rlen_q, rlen_d;
  logic [1:0]                rburst_q, rburst_d;
  logic [7:0]                rcnt_q, rcnt_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rlast_q, rlast_d;

  logic                      w_in_range, w_beat_last, mem_we;
  logic [IDX_W-1:0]          w_idx;
  logic [AXI_ADDR_WIDTH-1:0] r_ld_addr;
  logic [1:0]                r_ld_burst;
  logic                      r_ld_in_range, r_ld_ok;
  logic [AXI_DATA_WIDTH-1:0] r_ld_data;
  logic [1:0]                r_ld_resp;

`ifdef AXI_SLV_RANGE_CHECK_EN
  assign w_in_range    = (waddr_q[AXI_ADDR_WIDTH-1:IDX_W+3] == '0);
  assign r_ld_in_range = (r_ld_addr[AXI_ADDR_WIDTH-1:IDX_W+3] == '0);
`else
  assign w_in_range    = 1'b1;
  assign r_ld_in_range = 1'b1;
`endif

  assign w_idx       = waddr_q[3 +: IDX_W];
  assign w_beat_last = (wcnt_q == wlen_q);
  assign mem_we      = reset && (w_state_q == W_DATA) && s_axi_wvalid &&
                       !wburst_q[1] && w_in_range;

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    wresp_d   = wresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          w_state_d = W_DATA;
          wid_d     = s_axi_awid;
          waddr_d   = s_axi_awaddr;
          wlen_d    = s_axi_awlen;
          wburst_d  = s_axi_awburst;
          wcnt_d    = 8'd0;
          wresp_d   = s_axi_awburst[1] ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          // wlast must coincide with the counted last beat; the count still drives completion
          if ((s_axi_wlast != w_beat_last) || !w_in_range) wresp_d = RESP_SLVERR;
          if (wburst_q == BURST_INCR) waddr_d = waddr_q + BEAT_BYTES;
          wcnt_d = wcnt_q + 8'd1;
          if (w_beat_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Address of the beat being loaded into the read output register this cycle
  always_comb begin
    r_ld_addr  = raddr_q + ((rburst_q == BURST_INCR) ? BEAT_BYTES : '0);
    r_ld_burst = rburst_q;
    if (r_state_q == R_IDLE) begin
      r_ld_addr  = s_axi_araddr;
      r_ld_burst = s_axi_arburst;
    end
  end

  assign r_ld_ok   = !r_ld_burst[1] && r_ld_in_range;
  assign r_ld_data = r_ld_ok ? mem[r_ld_addr[3 +: IDX_W]] : '0;
  assign r_ld_resp = r_ld_ok ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          r_state_d = R_DATA;
          rid_d     = s_axi_arid;
          raddr_d   = s_axi_araddr;
          rlen_d    = s_axi_arlen;
          rburst_d  = s_axi_arburst;
          rcnt_d    = 8'd0;
          rdata_d   = r_ld_data;
          rresp_d   = r_ld_resp;
          rlast_d   = (s_axi_arlen == 8'd0);
        end
      end
      default: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            raddr_d = r_ld_addr;
            rcnt_d  = rcnt_q + 8'd1;
            rdata_d = r_ld_data;
            rresp_d = r_ld_resp;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      wresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      wresp_q   <= wresp_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < AXI_STROBE_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = wresp_q;
  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign busy          = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_arsize, waddr_q[2:0], r_ld_addr[2:0],
                       waddr_q[AXI_ADDR_WIDTH-1:IDX_W+3], r_ld_addr[AXI_ADDR_WIDTH-1:IDX_W+3]};

endmodule

// File: tb/tb_axi_slave_scratchpad.sv
// tb/tb_axi_slave_scratchpad.sv - self-checking bench for axi_slave_scratchpad
// Vector table plus hand sequences plus randomized traffic against a word-array reference model.
module tb_axi_slave_scratchpad;

  localparam int MEM_WORDS = 1024;
`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready, busy;

  axi_slave_scratchpad dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] ref_mem [MEM_WORDS];
  logic [63:0] wr_data [256];
  logic [7:0]  wr_strb [256];
  logic        wr_last [256];
  logic [63:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [7:0]  rd_id   [256];
  int          rd_nbeats;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] seed;
    int          last_at;
    logic [1:0]  exp_b;
    logic [1:0]  exp_r0;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic longint unsigned beat_word(input logic [31:0] addr, input logic [1:0] burst, input int b);
    return longint'(addr >> 3) + ((burst == 2'b01) ? longint'(b) : 64'd0);
  endfunction

  function automatic logic [63:0] exp_rdata(input logic [31:0] addr, input logic [1:0] burst, input int b);
    longint unsigned w = beat_word(addr, burst, b);
    if (burst[1] || (RC && w >= MEM_WORDS)) return 64'd0;
    return ref_mem[int'(w % MEM_WORDS)];
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] addr, input logic [1:0] burst, input int b);
    longint unsigned w = beat_word(addr, burst, b);
    return (burst[1] || (RC && w >= MEM_WORDS)) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             output logic [1:0] resp);
    longint unsigned w;
    resp = 2'b00;
    for (int b = 0; b <= int'(len); b++) begin
      w = beat_word(addr, burst, b);
      if (wr_last[b] != (b == int'(len))) resp = 2'b10;
      if (burst[1] || (RC && w >= MEM_WORDS)) resp = 2'b10;
      else
        for (int i = 0; i < 8; i++)
          if (wr_strb[b][i]) ref_mem[int'(w % MEM_WORDS)][8*i +: 8] = wr_data[b][8*i +: 8];
    end
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output logic [1:0] resp, output logic [7:0] bid_o);
    int cyc;
    int stall;
    logic [7:0] h_id;
    logic [1:0] h_resp;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    cyc = 0;
    while (!s_axi_awready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 100) fail_now("aw_wait");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    check("awready_low_in_burst", s_axi_awready, 1'b0);
    for (int b = 0; b <= int'(len); b++) begin
      s_axi_wdata = wr_data[b]; s_axi_wstrb = wr_strb[b]; s_axi_wlast = wr_last[b];
      s_axi_wvalid = 1'b1;
      cyc = 0;
      while (!s_axi_wready && cyc < 100) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 100) fail_now("w_wait");
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    cyc = 0;
    while (!s_axi_bvalid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!s_axi_bvalid) fail_now("b_wait");
    h_id = s_axi_bid; h_resp = s_axi_bresp;
    stall = $urandom_range(0, 2);
    repeat (stall) begin
      @(posedge clk); #1;
      check("b_hold", {s_axi_bvalid, s_axi_bid, s_axi_bresp}, {1'b1, h_id, h_resp});
    end
    resp = s_axi_bresp; bid_o = s_axi_bid;
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("bvalid_drop", s_axi_bvalid, 1'b0);
  endtask

  // mode 0: rready always high, 1: pattern 1,0,0 repeating, 2: random
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int mode, input int stop_after);
    int cyc, k, got;
    logic stalled;
    logic [63:0] hd;
    logic [1:0] hr;
    logic hl;
    logic [7:0] hi;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    cyc = 0;
    while (!s_axi_arready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 100) fail_now("ar_wait");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check("rvalid_after_ar", s_axi_rvalid, 1'b1);
    got = 0; k = 0; stalled = 1'b0; cyc = 0;
    hd = '0; hr = '0; hl = 1'b0; hi = '0;
    while (got < int'(len) + 1 && got < stop_after && cyc < 4000) begin
      s_axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      if (stalled) begin
        check("r_hold_valid", s_axi_rvalid, 1'b1);
        check("r_hold_payload", {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}, {hd, hr, hl, hi});
      end
      if (s_axi_rvalid) begin
        if (s_axi_rready) begin
          rd_data[got] = s_axi_rdata; rd_resp[got] = s_axi_rresp;
          rd_last[got] = s_axi_rlast; rd_id[got] = s_axi_rid;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast; hi = s_axi_rid;
        end
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_axi_rready = 1'b0;
    if (cyc >= 4000) fail_now("r_wait");
    rd_nbeats = got;
  endtask

  task automatic compare_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst);
    check("r_beat_count", rd_nbeats, int'(len) + 1);
    for (int b = 0; b < rd_nbeats; b++) begin
      check("r_data", rd_data[b], exp_rdata(addr, burst, b));
      check("r_resp", rd_resp[b], exp_rresp(addr, burst, b));
      check("r_last", rd_last[b], b == int'(len));
      check("r_id", rd_id[b], id);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp, mresp;
    logic [7:0] bid_o;
    logic [63:0] old_v, new_v;
    logic [31:0] addr;
    logic [7:0] len;
    logic [1:0] burst;
    int bsel;

    vecs[0] = '{8'h01, 32'h100,  8'd0, 2'b01, 8'hFF, 64'h0123_4567_89AB_CDEF, 0,  2'b00, 2'b00};
    vecs[1] = '{8'h02, 32'h208,  8'd3, 2'b00, 8'hFF, 64'h1111_0000_2222_0001, 3,  2'b00, 2'b00};
    vecs[2] = '{8'h03, 32'h300,  8'd2, 2'b10, 8'hFF, 64'h5555_5555_5555_5555, 2,  2'b10, 2'b10};
    vecs[3] = '{8'h04, 32'h318,  8'd1, 2'b11, 8'hFF, 64'h7777_0000_7777_0000, 1,  2'b10, 2'b10};
    vecs[4] = '{8'h05, 32'h400,  8'd3, 2'b01, 8'hA5, 64'hDEAD_BEEF_CAFE_F00D, 3,  2'b00, 2'b00};
    vecs[5] = '{8'h06, 32'h500,  8'd3, 2'b01, 8'hFF, 64'h0000_0000_0000_0101, -1, 2'b10, 2'b00};
    vecs[6] = '{8'h07, 32'h600,  8'd2, 2'b01, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 1,  2'b10, 2'b00};
    vecs[7] = '{8'h08, 32'h1FF0, 8'd3, 2'b01, 8'hFF, 64'h1234_0000_0000_4321, 3,  RC ? 2'b10 : 2'b00, 2'b00};
    vecs[8] = '{8'h09, 32'h1FF8, 8'd1, 2'b01, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, 1,  RC ? 2'b10 : 2'b00, 2'b00};

    reset = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_rlast", s_axi_rlast, 1'b0);
    check("rst_resps", {s_axi_bresp, s_axi_rresp}, 4'b0);
    check("rst_ids", {s_axi_bid, s_axi_rid}, 16'b0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {s_axi_awready, s_axi_arready}, 2'b11);

    // Initialise all storage so every later read has a defined reference value
    for (int blk = 0; blk < MEM_WORDS / 256; blk++) begin
      for (int b = 0; b < 256; b++) begin
        wr_data[b] = {$urandom(), $urandom()}; wr_strb[b] = 8'hFF; wr_last[b] = (b == 255);
      end
      model_write(32'(blk * 2048), 8'd255, 2'b01, mresp);
      do_write(8'hF0, 32'(blk * 2048), 8'd255, 2'b01, resp, bid_o);
      check("fill_bresp", resp, 2'b00);
    end

    wr_data[0] = 64'h11; wr_data[1] = 64'h22; wr_data[2] = 64'h33; wr_data[3] = 64'h44;
    for (int b = 0; b < 4; b++) begin wr_strb[b] = 8'hFF; wr_last[b] = (b == 3); end
    model_write(32'h40, 8'd3, 2'b01, mresp);
    do_write(8'h19, 32'h40, 8'd3, 2'b01, resp, bid_o);
    check("incr4_bresp", resp, 2'b00);
    do_read(8'h19, 32'h40, 8'd3, 2'b01, 0, 256);
    check("incr4_d0", rd_data[0], 64'h11);
    check("incr4_d1", rd_data[1], 64'h22);
    check("incr4_d2", rd_data[2], 64'h33);
    check("incr4_d3", rd_data[3], 64'h44);
    check("incr4_last", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);

    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
    model_write(32'h28, 8'd0, 2'b01, mresp);
    do_write(8'h20, 32'h28, 8'd0, 2'b01, resp, bid_o);
    wr_data[0] = 64'd0; wr_strb[0] = 8'h0F;
    model_write(32'h28, 8'd0, 2'b01, mresp);
    do_write(8'h20, 32'h28, 8'd0, 2'b01, resp, bid_o);
    do_read(8'h20, 32'h28, 8'd0, 2'b01, 0, 256);
    check("strobe_merge", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    for (int v = 0; v < 9; v++) begin
      for (int b = 0; b <= int'(vecs[v].len); b++) begin
        wr_data[b] = vecs[v].seed * 64'(b + 1);
        wr_strb[b] = vecs[v].strb;
        wr_last[b] = (b == vecs[v].last_at);
      end
      model_write(vecs[v].addr, vecs[v].len, vecs[v].burst, mresp);
      do_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, resp, bid_o);
      check("tbl_bresp", resp, vecs[v].exp_b);
      check("tbl_bid", bid_o, vecs[v].id);
      do_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, 2, 256);
      check("tbl_rresp0", rd_resp[0], vecs[v].exp_r0);
      compare_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst);
    end

    do_read(8'hA5, 32'h800, 8'd7, 2'b01, 1, 256);
    compare_read(8'hA5, 32'h800, 8'd7, 2'b01);

    // Read and write of word 9 landing on the same clock edge
    old_v = ref_mem[9];
    new_v = 64'h5A5A_1234_A5A5_4321;
    s_axi_arid = 8'h21; s_axi_araddr = 32'h48; s_axi_arlen = 8'd1; s_axi_arburst = 2'b00;
    s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check("raw_beat0", {s_axi_rvalid, s_axi_rdata}, {1'b1, old_v});
    s_axi_awid = 8'h22; s_axi_awaddr = 32'h48; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = new_v; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("raw_beat1_old", {s_axi_rvalid, s_axi_rlast, s_axi_rdata}, {2'b11, old_v});
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    check("raw_done", {s_axi_rvalid, s_axi_bvalid}, 2'b00);
    ref_mem[9] = new_v;
    do_read(8'h23, 32'h48, 8'd0, 2'b01, 0, 256);
    check("raw_new", rd_data[0], new_v);

    do_read(8'h3C, 32'h80, 8'd7, 2'b01, 0, 2);
    check("midburst_rvalid", s_axi_rvalid, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_rvalid_busy", {s_axi_rvalid, busy}, 2'b00);
    check("rst_mid_payload", {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}, 75'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_arready", {s_axi_arready, s_axi_awready, busy}, 3'b110);
    do_read(8'h3D, 32'h80, 8'd3, 2'b01, 2, 256);
    compare_read(8'h3D, 32'h80, 8'd3, 2'b01);

    for (int t = 0; t < 40; t++) begin
      addr = 32'($urandom_range(0, MEM_WORDS - 1)) * 32'd8 + 32'($urandom_range(0, 7));
      len = 8'($urandom_range(0, 7));
      bsel = $urandom_range(0, 9);
      burst = (bsel < 5) ? 2'b01 : (bsel < 8) ? 2'b00 : (bsel == 8) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= int'(len); b++) begin
          wr_data[b] = {$urandom(), $urandom()};
          wr_strb[b] = 8'($urandom_range(0, 255));
          wr_last[b] = (b == int'(len)) ^ ($urandom_range(0, 9) == 0);
        end
        model_write(addr, len, burst, mresp);
        do_write(8'(t), addr, len, burst, resp, bid_o);
        check("rnd_bresp", resp, mresp);
        check("rnd_bid", bid_o, 8'(t));
      end else begin
        do_read(8'(t + 100), addr, len, burst, 2, 256);
        compare_read(8'(t + 100), addr, len, burst);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_slave_scratchpad.md
AXI_SLAVE_SCRATCHPAD -- requirements
Module: axi_slave_scratchpad

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- AXI_DATA_WIDTH, 64, data bus width.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_TID_WIDTH, 8, ID width.
- AXI_STROBE_WIDTH, 8, byte strobes.
- MEM_WORDS, 1024, 64-bit words of storage (power of two).

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the one clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst/awvalid, in, TID/ADDR/8/3/2/1: write address; awready, out, 1.
- s_axi_wdata/wstrb/wlast/wvalid, in, DATA/STROBE/1/1: write data; wready, out, 1.
- s_axi_bid/bresp/bvalid, out, TID/2/1: write response; bready, in, 1.
- s_axi_arid/araddr/arlen/arsize/arburst/arvalid, in, TID/ADDR/8/3/2/1: read address; arready, out, 1.
- s_axi_rid/rdata/rresp/rlast/rvalid, out, TID/DATA/2/1/1: read data; rready, in, 1.
- busy, out, 1: high while either channel FSM is not idle.

REQ-003 SHALL ignore awsize and arsize. Every beat is full width (8 bytes).

Function
REQ-004 SHALL index word addr[3 +: log2(MEM_WORDS)].
REQ-005 SHALL use two independent FSMs:
- Write: W_IDLE, W_DATA, W_RESP.
- Read: R_IDLE, R_DATA.

REQ-006 Write FSM:
- W_IDLE drives awready=1. An AW handshake latches id, addr, len and burst, then moves to W_DATA.
- W_DATA drives wready=1. Each W handshake writes only the bytes whose wstrb bit is set.
- A FIXED burst keeps the same word. An INCR burst advances one word per beat.

REQ-007 Burst end: after beat awlen+1, the write FSM SHALL move to W_RESP.
- wlast must be high on that beat and low on all earlier beats.
- Any mismatch sets the latched response to SLVERR (2'b10). Beats still complete the count.

REQ-008 W_RESP SHALL drive bvalid=1, bid set to the latched id, and bresp (OKAY 2'b00 or SLVERR). It holds these until bready, then returns to W_IDLE.

REQ-009 Read FSM:
- R_IDLE drives arready=1. An AR handshake moves to R_DATA.
- rvalid SHALL be high the cycle after the AR handshake.
- Each R handshake presents the next beat in the following cycle, so back-to-back beats sustain one beat per cycle.
- rlast SHALL be high on beat arlen+1. The FSM returns to R_IDLE on that handshake.

REQ-010 While valid is high and ready is low, rdata, rid, rresp, rlast and bid/bresp SHALL stay stable. valid SHALL never drop before its handshake.

REQ-011 A burst type of WRAP or 2'b11:
- Write: data is discarded and bresp is SLVERR.
- Read: rdata is 0 and rresp is SLVERR on every beat.
- Beat count and rlast behave normally.

REQ-012 A read and a write to the same word in the same cycle SHALL return the pre-write data.
REQ-013 An INCR burst SHALL wrap its word index modulo MEM_WORDS, unless REQ-017 applies.
REQ-014 awready and arready SHALL be 0 outside their idle states. No outstanding-transaction queueing: one write and one read in flight at most.

Reset
REQ-015 With reset=0 at a clk edge, the block SHALL:
- put both FSMs in their idle states;
- drive bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0 and busy=0;
- drive awready=1 and arready=1 from the first cycle after reset deasserts.

REQ-016 Memory contents SHALL NOT be reset. Reset mid-burst SHALL abandon the burst with no response issued.

Configuration
REQ-017 When AXI_SLV_RANGE_CHECK_EN is defined, a beat whose byte address is at or above MEM_WORDS*8:
- on write, SHALL not be written and SHALL set the burst response to SLVERR;
- on read, SHALL return rdata=0 and rresp=SLVERR for that beat only.

REQ-018 When AXI_SLV_RANGE_CHECK_EN is not defined, the address SHALL wrap per REQ-013 and no SLVERR is raised for range.

Verification
REQ-019 INCR write awaddr=0x40, awlen=3, data 0x11..0x44, wstrb=0xFF, then read araddr=0x40, arlen=3 -> bresp=OKAY; rdata 0x11,0x22,0x33,0x44 with rlast on beat 4 only.

REQ-020 Write 0xFFFF_FFFF_FFFF_FFFF to word 5, then write wstrb=0x0F data 0 -> read returns 0xFFFF_FFFF_0000_0000.

REQ-021 Read arlen=7 with rready toggled 1,0,0,1,... -> rdata stable during stalls; 8 beats delivered; rid equals arid=0xA5.

REQ-022 Write awlen=2 with wlast on beat 2 -> 3 beats accepted; bresp=SLVERR; bid equals awid.

REQ-023 With AXI_SLV_RANGE_CHECK_EN, read araddr=MEM_WORDS*8-8, arlen=1 -> beat 1 OKAY with stored data; beat 2 SLVERR with rdata=0. Without the macro, beat 2 returns word 0.

REQ-024 Assert reset=0 mid read burst, then release -> rvalid=0 and busy=0; arready=1 next cycle; a new read completes correctly.
